// File: rtl/fft_stage_sequencer_if.sv
// Control/address bundle between the FFT stage sequencer and the butterfly/RAM datapath.
// The cycle_count signal exists only when FFT_SEQ_CYCLE_COUNT_EN is defined.
interface fft_stage_sequencer_if #(
    parameter int LOG2_N = 4,
    parameter int SW     = 2
);
    logic              enable;
    logic              start;
    logic              busy;
    logic              done;
    logic [SW-1:0]     stage;
    logic              rd_en;
    logic [LOG2_N-1:0] rd_addr0;
    logic [LOG2_N-1:0] rd_addr1;
    logic [LOG2_N-2:0] tw_idx;
    logic              bfly_type2;
    logic              wr_en;
    logic [LOG2_N-1:0] wr_addr0;
    logic [LOG2_N-1:0] wr_addr1;
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    logic [15:0]       cycle_count;
`endif

    modport master (
`ifdef FFT_SEQ_CYCLE_COUNT_EN
        output cycle_count,
`endif
        input  enable, start,
        output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx, bfly_type2,
        output wr_en, wr_addr0, wr_addr1
    );

    modport slave (
`ifdef FFT_SEQ_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        output enable, start,
        input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx, bfly_type2,
        input  wr_en, wr_addr0, wr_addr1
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIF FFT stage sequencer: issues read pairs/twiddles per stage and replays them as writes L cycles later.
// Optional cycle counter enabled by defining FFT_SEQ_CYCLE_COUNT_EN.
module fft_stage_sequencer #(
    parameter int LOG2_N         = 4,
    parameter int MEM_RD_LATENCY = 1,
    parameter int BFLY_LATENCY   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fft_stage_sequencer_if.master  bus
);
    localparam int N      = 1 << LOG2_N;
    localparam int L      = MEM_RD_LATENCY + BFLY_LATENCY;
    localparam int SW_RAW = $clog2(LOG2_N);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int KW     = LOG2_N - 1;
    localparam int DW     = $clog2(L + 1);

    localparam logic [KW-1:0] K_LAST  = '1;
    localparam logic [SW-1:0] S_LAST  = SW'(LOG2_N - 1);
    localparam logic [DW-1:0] DC_LAST = DW'(L - 1);
    localparam logic [KW-1:0] TW_Q    = KW'(N / 4);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] dc_q, dc_d;

    logic issue_w, busy_w, done_w, rd_en_w, start_acc_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dc_q    <= dc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        k_d         = k_q;
        dc_d        = dc_q;
        issue_w     = (state_q == S_ISSUE);
        busy_w      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done_w      = (state_q == S_DONE) && bus.enable;
        rd_en_w     = issue_w && bus.enable;
        start_acc_w = (state_q == S_IDLE) && bus.enable && bus.start;
        if (bus.enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        s_d     = '0;
                        k_d     = '0;
                        dc_d    = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        dc_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                // Drain lets the last write of this stage land before the next stage reads.
                S_DRAIN: begin
                    if (dc_q == DC_LAST) begin
                        dc_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            s_d     = s_q + SW'(1);
                            state_d = S_ISSUE;
                        end
                    end else begin
                        dc_d = dc_q + DW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Group/offset split of k by masking with span-1, so no divider is needed.
    logic [LOG2_N-1:0] span_w, mask_w, k_ext_w, j_w, a0_w;
    logic [KW-1:0]     tw_w;

    always_comb begin
        span_w  = LOG2_N'(N >> (int'(s_q) + 1));
        mask_w  = span_w - LOG2_N'(1);
        k_ext_w = {1'b0, k_q};
        j_w     = k_ext_w & mask_w;
        a0_w    = ((k_ext_w & ~mask_w) << 1) | j_w;
        tw_w    = KW'(j_w << s_q);
    end

    assign bus.busy       = busy_w;
    assign bus.done       = done_w;
    assign bus.stage      = busy_w ? s_q : '0;
    assign bus.rd_en      = rd_en_w;
    assign bus.rd_addr0   = issue_w ? a0_w : '0;
    assign bus.rd_addr1   = issue_w ? (a0_w | span_w) : '0;
    assign bus.tw_idx     = issue_w ? tw_w : '0;
    assign bus.bfly_type2 = issue_w && (tw_w == TW_Q);

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_dl
            logic              en_q;
            logic [LOG2_N-1:0] a0_q, a1_q;
            logic              en_in;
            logic [LOG2_N-1:0] a0_in, a1_in;

            if (gi == 0) begin : g_src
                assign en_in = issue_w;
                assign a0_in = bus.rd_addr0;
                assign a1_in = bus.rd_addr1;
            end else begin : g_src
                assign en_in = g_dl[gi-1].en_q;
                assign a0_in = g_dl[gi-1].a0_q;
                assign a1_in = g_dl[gi-1].a1_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_q <= 1'b0;
                    a0_q <= '0;
                    a1_q <= '0;
                end else if (bus.enable) begin
                    en_q <= en_in;
                    a0_q <= a0_in;
                    a1_q <= a1_in;
                end
            end
        end
    endgenerate

    assign bus.wr_en    = g_dl[L-1].en_q && bus.enable;
    assign bus.wr_addr0 = g_dl[L-1].a0_q;
    assign bus.wr_addr1 = g_dl[L-1].a1_q;

`ifdef FFT_SEQ_CYCLE_COUNT_EN
    // Counts stalled busy cycles too, so it measures wall-clock run length.
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_acc_w) begin
            cnt_q <= '0;
        end else if (busy_w) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.cycle_count = cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc_w;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: per-cycle comparison against a trace built from the DIF schedule rules.
module tb_fft_stage_sequencer;
    localparam int LOG2_N = 4;
    localparam int MRL    = 1;
    localparam int BL     = 1;
    localparam int L      = MRL + BL;
    localparam int N      = 1 << LOG2_N;
    localparam int H      = N / 2;
    localparam int SW     = 2;
    localparam int T_DONE = 1 + LOG2_N * (H + L);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fft_stage_sequencer_if #(.LOG2_N(LOG2_N), .SW(SW)) bus ();

    fft_stage_sequencer #(
        .LOG2_N(LOG2_N),
        .MEM_RD_LATENCY(MRL),
        .BFLY_LATENCY(BL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected trace indexed by run cycle (1 = first issue cycle, T_DONE = done cycle).
    bit e_rd  [0:T_DONE];
    bit e_wr  [0:T_DONE];
    bit e_t2  [0:T_DONE];
    int e_a0  [0:T_DONE];
    int e_a1  [0:T_DONE];
    int e_tw  [0:T_DONE];
    int e_wa0 [0:T_DONE];
    int e_wa1 [0:T_DONE];
    int e_stg [0:T_DONE];

    int mt    = 0;
    bit fresh = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr0, bus.rd_addr1,
                    bus.tw_idx, bus.bfly_type2, bus.wr_en, bus.wr_addr0, bus.wr_addr1});
    endfunction

    function automatic void build_model();
        for (int t = 0; t <= T_DONE; t++) begin
            e_rd[t] = 0; e_wr[t] = 0; e_t2[t] = 0;
            e_a0[t] = 0; e_a1[t] = 0; e_tw[t] = 0;
            e_wa0[t] = 0; e_wa1[t] = 0; e_stg[t] = 0;
        end
        for (int s = 0; s < LOG2_N; s++) begin
            int span;
            span = N >> (s + 1);
            for (int o = 0; o < H + L; o++) e_stg[1 + s * (H + L) + o] = s;
            for (int k = 0; k < H; k++) begin
                int t, g, j, a0;
                t  = 1 + s * (H + L) + k;
                g  = k / span;
                j  = k % span;
                a0 = 2 * g * span + j;
                e_rd[t]  = 1;
                e_a0[t]  = a0;
                e_a1[t]  = a0 + span;
                e_tw[t]  = (j << s) % H;
                e_t2[t]  = (e_tw[t] == N / 4);
                e_wr[t + L]  = 1;
                e_wa0[t + L] = a0;
                e_wa1[t + L] = a0 + span;
            end
        end
    endfunction

    // Run-position tracker: advances only on enabled edges, cleared by reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mt    = 0;
            fresh = 1'b1;
        end else if (bus.enable) begin
            if (mt == 0) begin
                if (bus.start) begin
                    mt    = 1;
                    fresh = 1'b0;
                end
            end else if (mt == T_DONE) begin
                mt = 0;
            end else begin
                mt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n || fresh) begin
            chk("idle_zero", outs(), 32'd0);
        end else begin
            chk("busy", 32'(bus.busy), 32'(mt >= 1 && mt < T_DONE));
            chk("rd_en", 32'(bus.rd_en), 32'(bus.enable & e_rd[mt]));
            chk("wr_en", 32'(bus.wr_en), 32'(bus.enable & e_wr[mt]));
            chk("done", 32'(bus.done), 32'(bus.enable && mt == T_DONE));
            if (e_rd[mt]) begin
                chk("rd_addr0", 32'(bus.rd_addr0), e_a0[mt]);
                chk("rd_addr1", 32'(bus.rd_addr1), e_a1[mt]);
                chk("tw_idx", 32'(bus.tw_idx), e_tw[mt]);
                chk("bfly_type2", 32'(bus.bfly_type2), 32'(e_t2[mt]));
            end
            if (e_wr[mt]) begin
                chk("wr_addr0", 32'(bus.wr_addr0), e_wa0[mt]);
                chk("wr_addr1", 32'(bus.wr_addr1), e_wa1[mt]);
            end
            if (mt >= 1 && mt < T_DONE) chk("stage", 32'(bus.stage), e_stg[mt]);
        end
    end

    // Starts a run from idle (caller is 1 time unit past an edge) and returns the done cycle, or -1.
    task automatic run(input int stall_at, input int pulse_at, input int abort_at,
                       input bit pin, output int dcyc);
        int c;
        dcyc = -1;
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        while (c < 120 && dcyc < 0) begin
            bus.enable = !(stall_at > 0 && c >= stall_at && c < stall_at + 5);
            bus.start  = (c == pulse_at);
            if (c == abort_at) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("abort_zero", outs(), 32'd0);
                $display("run stall=%0d pulse=%0d aborted at cycle %0d", stall_at, pulse_at, c);
                return;
            end
            @(negedge clk);
            if (bus.done) dcyc = c;
            if (pin && c == 5) begin
                chk("lit_c5_rd_addr0", 32'(bus.rd_addr0), 32'd4);
                chk("lit_c5_rd_addr1", 32'(bus.rd_addr1), 32'd12);
                chk("lit_c5_tw_idx", 32'(bus.tw_idx), 32'd4);
                chk("lit_c5_bfly_type2", 32'(bus.bfly_type2), 32'd1);
            end
            @(posedge clk); #1;
            c++;
        end
        bus.start  = 1'b0;
        bus.enable = 1'b1;
        $display("run stall=%0d pulse=%0d done_cycle=%0d", stall_at, pulse_at, dcyc);
    endtask

    initial begin
        int dc;
        build_model();

        // Literal pins on the model itself.
        chk("pin_s0_a0", e_a0[5], 32'd4);
        chk("pin_s0_a1", e_a1[5], 32'd12);
        chk("pin_s0_t2", 32'(e_t2[5]), 32'd1);
        chk("pin_s1_tw", e_tw[13], 32'd4);
        chk("pin_s1_a0", e_a0[17], 32'd10);
        chk("pin_s3_a1", e_a1[38], 32'd15);
        chk("pin_wb_a1", e_wa1[10], 32'd15);
        chk("pin_drain", 32'(e_rd[9] | e_rd[10]), 32'd0);

        // Reset with random inputs, then a quiet idle period.
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            bus.enable = 1'($urandom_range(0, 1));
            bus.start  = 1'($urandom_range(0, 1));
        end
        bus.start  = 1'b0;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        run(0, 0, 0, 1'b1, dc);
        chk("done_cycle_plain", dc, 32'd41);
        repeat (5) @(posedge clk);
        #1;

        run(6, 0, 0, 1'b0, dc);
        chk("done_cycle_stall", dc, 32'd46);
`ifdef FFT_SEQ_CYCLE_COUNT_EN
        chk("cycle_count_stall", 32'(bus.cycle_count), 32'd45);
`endif
        repeat (5) @(posedge clk);
        #1;

        run(0, 15, 20, 1'b0, dc);
        chk("abort_no_done", dc, 32'hffff_ffff);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        run(0, 0, 0, 1'b1, dc);
        chk("done_cycle_restart", dc, 32'd41);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
